// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder and decoder:
// opcode constants, field bit positions, the word type and format classes.
package isa_pkg;

  localparam logic [4:0] OP_CMP = 5'd6;
  localparam logic [4:0] OP_R11 = 5'd11;
  localparam logic [4:0] OP_LD  = 5'd12;
  localparam logic [4:0] OP_ST  = 5'd13;

  localparam int OP_HI   = 19;
  localparam int OP_LO   = 15;
  localparam int RD_HI   = 14;
  localparam int RD_LO   = 10;
  localparam int RT_HI   = 9;
  localparam int RT_LO   = 5;
  localparam int RS_HI   = 4;
  localparam int RS_LO   = 0;
  localparam int BAMT_HI = 14;
  localparam int BAMT_LO = 0;

  typedef logic [19:0] inst_t;

  typedef enum logic [1:0] {FMT_R, FMT_LD, FMT_ST, FMT_J} fmt_e;

  // Total classification: every opcode maps to exactly one format.
  function automatic fmt_e op_format(input logic [4:0] op);
    if (op <= OP_CMP || op == OP_R11) return FMT_R;
    else if (op == OP_LD)             return FMT_LD;
    else if (op == OP_ST)             return FMT_ST;
    else                              return FMT_J;
  endfunction

endpackage

// File: rtl/inst_fmt.sv
// Combinational packer: turns one decoded field set into a 20-bit word
// laid out exactly as the instruction decoder expects.
module inst_fmt
  import isa_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rt,
  input  logic [4:0]  rs,
  input  logic [14:0] bamt,
  output inst_t       word
);

  fmt_e fmt;

  // Opcode always occupies the top field; the rest depends on the format.
  always_comb begin
    fmt  = op_format(op);
    word = '0;
    word[OP_HI:OP_LO] = op;
    case (fmt)
      FMT_R, FMT_LD: begin
        word[RD_HI:RD_LO] = rd;
        word[RT_HI:RT_LO] = rt;
        word[RS_HI:RS_LO] = rs;
      end
      FMT_ST: begin
        // Stores have no rs operand; the field stays zero.
        word[RD_HI:RD_LO] = rd;
        word[RT_HI:RT_LO] = rt;
      end
      default: begin
        word[BAMT_HI:BAMT_LO] = bamt;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming instruction encoder / program loader. Accepts field sets over
// valid/ready, packs them, and writes them to consecutive imem addresses
// from a captured base. Overflowing the top of memory drops the write and
// raises a sticky err, while still draining the session to its last set.
module inst_encoder
  import isa_pkg::*;
#(
  parameter int AW = 10
)
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rs,
  input  logic [14:0]   in_bamt,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [19:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e        state_reg, state_next;
  logic [AW-1:0] ptr_reg, ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          full_reg, full_next;
  logic          err_reg, err_next;
  logic          we_reg, we_next;
  logic [AW-1:0] addr_reg, addr_next;
  inst_t         wdata_reg, wdata_next;
  inst_t         enc_word;
  logic          accept;

  inst_fmt u_fmt (
    .op   (in_op),
    .rd   (in_rd),
    .rt   (in_rt),
    .rs   (in_rs),
    .bamt (in_bamt),
    .word (enc_word)
  );

  assign accept = in_valid && (state_reg == S_LOAD);

  // Next-state and datapath update; registers hold unless a case overrides.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    full_next  = full_reg;
    err_next   = err_reg;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
          ptr_next   = base_addr;
          count_next = '0;
          err_next   = 1'b0;
          full_next  = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (!full_reg) begin
            we_next    = 1'b1;
            addr_next  = ptr_reg;
            wdata_next = enc_word;
            ptr_next   = ptr_reg + 1'b1;
            count_next = count_reg + 1'b1;
            // Last address just used: the wrapped pointer must not be reused.
            if (&ptr_reg) full_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          if (in_last) state_next = S_DONE;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State and output registers; async reset aborts any session in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      ptr_reg   <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
      err_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
      full_reg  <= full_next;
      err_reg   <= err_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  assign in_ready   = (state_reg == S_LOAD);
  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE);
  assign err        = err_reg;
  assign count      = count_reg;
  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed sessions with literal
// expectations plus randomized sessions scored against a transaction model.
module tb_inst_encoder;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int NEVER = 32'h7fffffff;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_op = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rt = '0;
  logic [4:0]    in_rs = '0;
  logic [14:0]   in_bamt = '0;
  logic          in_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [19:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  inst_encoder #(.AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rt      (in_rt),
    .in_rs      (in_rs),
    .in_bamt    (in_bamt),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .count      (count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int due;
    int addr;
    int word;
  } wr_t;

  wr_t wq[$];
  int  m_base, m_n, m_cnt;
  bit  m_err;
  int  sess_start_cyc = NEVER;
  int  sess_done_cyc  = NEVER;
  int  err_set_cyc    = NEVER;
  int  err_clr_cyc    = 0;

  function automatic int expect_word(input int op, input int rd, input int rt,
                                     input int rs, input int bamt);
    if (op <= 6 || op == 11 || op == 12) return op * 32768 + rd * 1024 + rt * 32 + rs;
    if (op == 13) return op * 32768 + rd * 1024 + rt * 32;
    return op * 32768 + bamt;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_we", imem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", count, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
      end else begin
        bit exp_we, exp_busy, exp_ready, exp_done, exp_err;
        while (wq.size() > 0 && wq[0].due < cyc) void'(wq.pop_front());
        exp_we    = (wq.size() > 0 && wq[0].due == cyc);
        exp_busy  = (cyc >= sess_start_cyc) && (cyc <= sess_done_cyc);
        exp_ready = exp_busy && (cyc < sess_done_cyc);
        exp_done  = (cyc == sess_done_cyc);
        exp_err   = (cyc >= err_set_cyc) && !(err_clr_cyc > err_set_cyc && cyc >= err_clr_cyc);
        chk("imem_we", imem_we, exp_we);
        if (exp_we) begin
          chk("imem_addr", imem_addr, wq[0].addr);
          chk("imem_wdata", imem_wdata, wq[0].word);
          void'(wq.pop_front());
        end
        chk("busy", busy, exp_busy);
        chk("in_ready", in_ready, exp_ready);
        chk("done", done, exp_done);
        chk("err", err, exp_err);
        if (exp_done) chk("done_count", count, m_cnt);
        if (cyc == sess_start_cyc) chk("start_count", count, 0);
      end
    end
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic begin_session(input int b);
    start     = 1'b1;
    base_addr = b[AW-1:0];
    in_valid  = 1'($urandom_range(0, 1));
    m_base = b; m_n = 0; m_cnt = 0;
    sess_start_cyc = cyc + 1;
    sess_done_cyc  = NEVER;
    if (m_err) err_clr_cyc = cyc + 1;
    m_err = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send_set(input int op, input int rd, input int rt, input int rs,
                          input int bamt, input bit last);
    int a;
    in_valid = 1'b1;
    in_op = op[4:0]; in_rd = rd[4:0]; in_rt = rt[4:0]; in_rs = rs[4:0];
    in_bamt = bamt[14:0]; in_last = last;
    a = m_base + m_n;
    if (a < DEPTH) begin
      wq.push_back('{due: cyc + 1, addr: a, word: expect_word(op, rd, rt, rs, bamt)});
      m_cnt++;
    end else if (!m_err) begin
      m_err = 1'b1;
      err_set_cyc = cyc + 1;
    end
    m_n++;
    if (last) sess_done_cyc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Gap cycle inside LOAD: no valid, occasionally a start that must be ignored.
  task automatic load_gap();
    in_valid  = 1'b0;
    in_op     = 5'($urandom);
    start     = ($urandom_range(0, 3) == 0);
    base_addr = AW'($urandom);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles outside LOAD: junk in_valid must be ignored.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_op    = 5'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; start = 1'b0; in_last = 1'b0;
    wq.delete();
    sess_start_cyc = NEVER; sess_done_cyc = NEVER;
    err_set_cyc = NEVER; err_clr_cyc = 0; m_err = 1'b0; m_cnt = 0;
    #1;
    chk("async_rst_we", imem_we, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_addr", imem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_gap(2);

    // Single-set R-type session.
    begin_session(32'h010);
    send_set(2, 3, 4, 5, 0, 1'b1);
    chk("t1_we", imem_we, 1);
    chk("t1_addr", imem_addr, 32'h010);
    chk("t1_wdata", imem_wdata, 32'h10C85);
    chk("t1_done", done, 1);
    chk("t1_count", count, 1);
    idle_gap(2);

    // Store zeroes rs; J-type carries bamt.
    begin_session(32'h100);
    send_set(13, 1, 2, 7, 0, 1'b0);
    chk("st_wdata", imem_wdata, 32'h68440);
    send_set(15, 9, 9, 9, 32'h1234, 1'b1);
    chk("j_wdata", imem_wdata, 32'h79234);
    chk("j_addr", imem_addr, 32'h101);
    idle_gap(1);

    // Four back-to-back sets including a compare.
    begin_session(32'h020);
    for (int i = 0; i < 4; i++) begin
      send_set((i == 1) ? 6 : 3 + i, i, i + 1, i + 2, 0, i == 3);
      chk("b2b_addr", imem_addr, 32'h020 + i);
      chk("b2b_we", imem_we, 1);
    end
    idle_gap(1);

    // Overflow at top of memory.
    begin_session(32'h3FE);
    for (int i = 0; i < 4; i++) send_set(1, i, i, i, 0, i == 3);
    chk("ovf_count", count, 2);
    chk("ovf_err", err, 1);
    chk("ovf_done", done, 1);
    idle_gap(1);
    begin_session(32'h000);
    chk("err_cleared", err, 0);
    send_set(12, 4, 5, 6, 0, 1'b1);
    idle_gap(1);

    // Reset mid-session.
    begin_session(32'h040);
    send_set(7, 0, 0, 0, 32'h7FFF, 1'b0);
    do_reset();
    idle_gap(3);

    // Randomized sessions.
    for (int s = 0; s < 40; s++) begin
      int b, n;
      bit aborted;
      aborted = 1'b0;
      b = ($urandom_range(0, 3) == 0) ? DEPTH - 1 - $urandom_range(0, 5)
                                      : $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 12);
      begin_session(b);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 2) == 0) load_gap();
        if ($urandom_range(0, 60) == 0) begin
          do_reset();
          aborted = 1'b1;
          break;
        end
        send_set($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 32767), k == n - 1);
      end
      if (!aborted) idle_gap(1 + $urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
